crossbar_grant_router: RTL and testbench
========================================

Name: crossbar_grant_router

Overview:
Data and return path of the stream crossbar, fed by the per-master-port round-robin grants. Each master (output) port locks onto its granted slave (input) port for one whole packet. It forwards that slave's beats through a one-entry output register and routes the master-side ready back to the owning slave. It sits between the slave-side stream inputs and the master-side stream outputs; the arbiter unit supplies grant_i.

Parameters:
T_DATA_WIDTH  8  data bus width per port
S_DATA_COUNT  2  number of slave (input) ports; minimum 2
M_DATA_COUNT  3  number of master (output) ports; minimum 2
T_ID___WIDTH  $clog2(S_DATA_COUNT)  localparam, slave id width
T_DEST_WIDTH  $clog2(M_DATA_COUNT)  localparam, destination width

Ports:
clk_i  in  1  single clock
rst_in  in  1  synchronous active-low reset
s_data_i  in  [S] x T_DATA_WIDTH  slave beat data
s_dest_i  in  [S] x T_DEST_WIDTH  destination master port per slave
s_last_i  in  S  last beat of packet
s_valid_i  in  S  slave beat valid
s_ready_o  out  S  slave beat accepted
grant_i  in  [M] x T_ID___WIDTH  arbiter-selected slave per master port
m_data_o  out  [M] x T_DATA_WIDTH  output data
m_id_o  out  [M] x T_ID___WIDTH  source slave id of beat
m_last_o  out  M  output last
m_valid_o  out  M  output valid
m_ready_i  in  M  downstream ready

Behaviour:
- Reset (rst_in low at a clock edge): all ports go to IDLE; owner registers 0; output registers empty; m_valid_o, m_last_o, m_data_o and m_id_o all 0. s_ready_o is 0 whenever every port is IDLE. Reset mid-packet drops any buffered beat with no flush.
- Per master port j, a two-state FSM:
  - IDLE: if s_valid_i[g] and s_dest_i[g]==j, with g=grant_i[j], then owner_j<=g and go to LOCKED. No beat is accepted in this cycle (lock bubble). If the granted slave is not requesting j, stay IDLE.
  - LOCKED: owner_j is frozen. grant_i[j] changes are ignored until the packet ends.
  - LOCKED -> IDLE on the accepted beat with s_last_i[owner_j]=1.
- Accept condition on port j: can_acc_j = !full_j || m_ready_i[j].
  - A beat is taken when LOCKED, s_valid_i[owner_j], s_dest_i[owner_j]==j and can_acc_j.
- s_ready_o[i] = OR over j of (LOCKED_j && owner_j==i && s_dest_i[i]==j && can_acc_j). This is combinational.
  - At most one j can match, because dest selects a single j.
- Dest change mid-packet is a protocol violation. Required behaviour: the beat stalls (no ready) until dest returns to j. No X propagates.
- Output register per port, one entry:
  - Load on an accepted beat: data, last and id=owner_j; full<=1.
  - If m_ready_i[j] && full_j and no load in the same cycle: full<=0.
  - Load and drain in the same cycle: full stays 1 and the new beat replaces the old one. This gives one beat per cycle throughput.
- m_valid_o[j]=full_j. m_data_o, m_last_o and m_id_o are held stable while m_valid_o && !m_ready_i.
- Latency: first beat on m_valid_o two cycles after s_valid_i rises (lock cycle plus register). Subsequent beats are one cycle after acceptance.
- Throughput: 1 beat/cycle per port, plus one bubble per packet.
- Ports are fully independent; disjoint slave->master pairs stream concurrently.
- Single-beat packet (valid and last together): lock, accept, and return to IDLE on the accept cycle.

Decomposition:
- Shared package crossbar_pkg:
  - enum route_state_t {IDLE, LOCKED}
  - width helper function (clog2 with minimum 1)
  - shared with the arbiter unit for T_ID___WIDTH/T_DEST_WIDTH
- One sub-module stream_out_reg:
  - one-entry pipeline register with valid/ready, data/last/id payload
  - instantiated M_DATA_COUNT times in a generate loop

Test Plan (S=2, M=3, W=8):
1. Slave0 dest=2 sends 0xA1, 0xA2(last); grant_i[2]=0; m_ready_i=1 -> lock at cycle 1. m_valid_o[2] shows 0xA1 at cycle 2 and 0xA2 with last at cycle 3, m_id_o[2]=0. Then IDLE, and s_ready_o[0] drops.
2. Same packet with m_ready_i[2]=0 after the first beat -> s_ready_o[0]=0, and m_data_o[2]=0xA1 is held stable. Releasing ready drains in order with no loss or duplication.
3. Slaves 0 and 1 both dest=1, grant_i[1]=1 -> slave1's 3-beat packet completes with m_id_o[1]=1. Toggling grant_i[1] to 0 mid-packet has no effect. Slave0 locks on the cycle after slave1's last.
4. Slave0->port0 and slave1->port2 simultaneously, 4 beats each -> both ports output 1 beat/cycle in parallel, with s_ready_o=2'b11 during the bodies.
5. rst_in low for one cycle mid-packet at port 1 -> next cycle m_valid_o=0, s_ready_o=0 and the FSM is IDLE. A fresh packet after reset locks normally.
6. grant_i[0]=1 while only slave0 requests port 0 -> port 0 stays IDLE, s_ready_o[0]=0 and m_valid_o[0]=0 until the grant becomes 0.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared types and width helpers for the stream crossbar (router and arbiter).
package crossbar_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } route_state_t;

    // $clog2 clamped to 1 so a select field never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        int width;
        width = $clog2(value);
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/crossbar_grant_router_if.sv
// Slave-side inputs, arbiter grants and master-side outputs of the crossbar data path.
interface crossbar_grant_router_if
    import crossbar_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3
);
    localparam int T_ID___WIDTH = clog2_min1(S_DATA_COUNT);
    localparam int T_DEST_WIDTH = clog2_min1(M_DATA_COUNT);

    logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i;
    logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i;
    logic [S_DATA_COUNT-1:0]                   s_last_i;
    logic [S_DATA_COUNT-1:0]                   s_valid_i;
    logic [S_DATA_COUNT-1:0]                   s_ready_o;
    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_i;
    logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o;
    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] m_id_o;
    logic [M_DATA_COUNT-1:0]                   m_last_o;
    logic [M_DATA_COUNT-1:0]                   m_valid_o;
    logic [M_DATA_COUNT-1:0]                   m_ready_i;

    // The router itself.
    modport slave (
        input  s_data_i, s_dest_i, s_last_i, s_valid_i, grant_i, m_ready_i,
        output s_ready_o, m_data_o, m_id_o, m_last_o, m_valid_o
    );

    // Sources, arbiter and downstream sinks around the router.
    modport master (
        output s_data_i, s_dest_i, s_last_i, s_valid_i, grant_i, m_ready_i,
        input  s_ready_o, m_data_o, m_id_o, m_last_o, m_valid_o
    );

endinterface

// File: rtl/crossbar_grant_router_stream_out_reg.sv
// One-entry valid/ready output register; a load and a drain in the same cycle
// replace the held beat, giving one beat per cycle.
module stream_out_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_in,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic [ID_WIDTH-1:0]   in_id,
    output logic                  can_accept,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [ID_WIDTH-1:0]   out_id
);

    logic                  full_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  last_reg;
    logic [ID_WIDTH-1:0]   id_reg;

    // Payload only moves on a load, and a load needs can_accept, so the
    // outputs stay frozen while stalled.
    assign can_accept = !full_reg || out_ready;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            full_reg <= 1'b0;
            data_reg <= '0;
            last_reg <= 1'b0;
            id_reg   <= '0;
        end else begin
            if (load) begin
                full_reg <= 1'b1;
                data_reg <= in_data;
                last_reg <= in_last;
                id_reg   <= in_id;
            end else if (out_ready && full_reg) begin
                full_reg <= 1'b0;
            end
        end
    end

    assign out_valid = full_reg;
    assign out_data  = data_reg;
    assign out_last  = last_reg;
    assign out_id    = id_reg;

endmodule

// File: rtl/crossbar_grant_router.sv
// Crossbar data/return path: each master port locks onto its granted slave for a
// whole packet, buffers beats in a one-entry register and steers ready back.
module crossbar_grant_router
    import crossbar_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3
) (
    input logic                     clk_i,
    input logic                     rst_in,
    crossbar_grant_router_if.slave  bus
);

    localparam int T_ID___WIDTH = clog2_min1(S_DATA_COUNT);
    localparam int T_DEST_WIDTH = clog2_min1(M_DATA_COUNT);

    localparam logic [0:0] ST_IDLE   = 1'(IDLE);
    localparam logic [0:0] ST_LOCKED = 1'(LOCKED);

    // ready_mat[slave][port]: port is currently willing to take a beat from slave.
    logic [S_DATA_COUNT-1:0][M_DATA_COUNT-1:0] ready_mat;

    genvar gi;
    genvar gs;

    generate
        for (gi = 0; gi < M_DATA_COUNT; gi++) begin : g_port
            logic [0:0]              state_reg;
            logic [0:0]              state_next;
            logic [T_ID___WIDTH-1:0] owner_reg;
            logic [T_ID___WIDTH-1:0] owner_next;
            logic [T_ID___WIDTH-1:0] grant;
            logic                    grant_req;
            logic                    owner_req;
            logic                    locked;
            logic                    can_acc;
            logic                    take;
            logic                    out_valid;
            logic [T_DATA_WIDTH-1:0] out_data;
            logic                    out_last;
            logic [T_ID___WIDTH-1:0] out_id;

            assign grant  = bus.grant_i[gi];
            assign locked = (state_reg == ST_LOCKED);

            // Guard against grant codes beyond the last slave when S is not a power of two.
            always_comb begin
                grant_req = 1'b0;
                if (int'(grant) < S_DATA_COUNT) begin
                    grant_req = bus.s_valid_i[grant] &&
                                (bus.s_dest_i[grant] == T_DEST_WIDTH'(gi));
                end
            end

            // A dest that moves away mid-packet simply stalls the owner here.
            assign owner_req = bus.s_valid_i[owner_reg] &&
                               (bus.s_dest_i[owner_reg] == T_DEST_WIDTH'(gi));
            assign take      = locked && owner_req && can_acc;

            always_comb begin
                state_next = state_reg;
                owner_next = owner_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (grant_req) begin
                            state_next = ST_LOCKED;
                            owner_next = grant;
                        end
                    end
                    default: begin
                        if (take && bus.s_last_i[owner_reg]) begin
                            state_next = ST_IDLE;
                        end
                    end
                endcase
            end

            always_ff @(posedge clk_i) begin
                if (!rst_in) begin
                    state_reg <= ST_IDLE;
                    owner_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    owner_reg <= owner_next;
                end
            end

            stream_out_reg #(
                .DATA_WIDTH (T_DATA_WIDTH),
                .ID_WIDTH   (T_ID___WIDTH)
            ) u_out_reg (
                .clk_i      (clk_i),
                .rst_in     (rst_in),
                .load       (take),
                .in_data    (bus.s_data_i[owner_reg]),
                .in_last    (bus.s_last_i[owner_reg]),
                .in_id      (owner_reg),
                .can_accept (can_acc),
                .out_ready  (bus.m_ready_i[gi]),
                .out_valid  (out_valid),
                .out_data   (out_data),
                .out_last   (out_last),
                .out_id     (out_id)
            );

            assign bus.m_valid_o[gi] = out_valid;
            assign bus.m_data_o[gi]  = out_data;
            assign bus.m_last_o[gi]  = out_last;
            assign bus.m_id_o[gi]    = out_id;

            for (gs = 0; gs < S_DATA_COUNT; gs++) begin : g_ready
                assign ready_mat[gs][gi] = locked &&
                                           (owner_reg == T_ID___WIDTH'(gs)) &&
                                           (bus.s_dest_i[gs] == T_DEST_WIDTH'(gi)) &&
                                           can_acc;
            end
        end
    endgenerate

    // Dest picks a single port, so at most one bit per row can be set.
    generate
        for (gi = 0; gi < S_DATA_COUNT; gi++) begin : g_sready
            assign bus.s_ready_o[gi] = |ready_mat[gi];
        end
    endgenerate

endmodule

// File: tb/tb_crossbar_grant_router.sv
// Directed bench for crossbar_grant_router (S=2, M=3, W=8) with per-port scoreboard.
module tb_crossbar_grant_router;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] dest;
        logic       last;
    } src_beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       id;
    } out_beat_t;

    logic clk = 1'b0;
    logic rst_in = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [1:0] acc;

    src_beat_t src_q0[$];
    src_beat_t src_q1[$];
    out_beat_t exp_q0[$];
    out_beat_t exp_q1[$];
    out_beat_t exp_q2[$];

    always #5 clk = ~clk;

    crossbar_grant_router_if #(
        .T_DATA_WIDTH (8),
        .S_DATA_COUNT (2),
        .M_DATA_COUNT (3)
    ) bus ();

    crossbar_grant_router #(
        .T_DATA_WIDTH (8),
        .S_DATA_COUNT (2),
        .M_DATA_COUNT (3)
    ) dut (
        .clk_i  (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    task automatic drive_src();
        bus.s_valid_i = '0;
        bus.s_data_i  = '0;
        bus.s_dest_i  = '0;
        bus.s_last_i  = '0;
        if (src_q0.size() > 0) begin
            bus.s_valid_i[0] = 1'b1;
            bus.s_data_i[0]  = src_q0[0].data;
            bus.s_dest_i[0]  = src_q0[0].dest;
            bus.s_last_i[0]  = src_q0[0].last;
        end
        if (src_q1.size() > 0) begin
            bus.s_valid_i[1] = 1'b1;
            bus.s_data_i[1]  = src_q1[0].data;
            bus.s_dest_i[1]  = src_q1[0].dest;
            bus.s_last_i[1]  = src_q1[0].last;
        end
    endtask

    // Queue an n-beat packet on slave s and the beats the port must emit for it.
    task automatic send(input int s, input logic [1:0] dest, input logic [7:0] first, input int n);
        src_beat_t sb;
        out_beat_t eb;
        for (int k = 0; k < n; k++) begin
            sb.data = first + 8'(k);
            sb.dest = dest;
            sb.last = (k == n - 1);
            eb.data = sb.data;
            eb.last = sb.last;
            eb.id   = s[0];
            if (s == 0) src_q0.push_back(sb); else src_q1.push_back(sb);
            case (dest)
                2'd0:    exp_q0.push_back(eb);
                2'd1:    exp_q1.push_back(eb);
                default: exp_q2.push_back(eb);
            endcase
        end
        drive_src();
        #1;
    endtask

    // One clock: record handshakes away from the edge, then advance the sources.
    task automatic tick();
        @(negedge clk);
        acc = rst_in ? (bus.s_valid_i & bus.s_ready_o) : 2'b00;
        @(posedge clk);
        #1;
        if (acc[0] && src_q0.size() > 0) void'(src_q0.pop_front());
        if (acc[1] && src_q1.size() > 0) void'(src_q1.pop_front());
        drive_src();
        #1;
    endtask

    function automatic int pending();
        return src_q0.size() + src_q1.size() + exp_q0.size() + exp_q1.size() + exp_q2.size();
    endfunction

    task automatic wait_drain(input string tag);
        for (int n = 0; n < 40 && pending() != 0; n++) tick();
        chk(tag, 32'(pending()), 32'd0);
    endtask

    task automatic pop_exp(input int j, output out_beat_t want, output logic ok);
        ok   = 1'b0;
        want = '0;
        case (j)
            0: if (exp_q0.size() > 0) begin want = exp_q0.pop_front(); ok = 1'b1; end
            1: if (exp_q1.size() > 0) begin want = exp_q1.pop_front(); ok = 1'b1; end
            default: if (exp_q2.size() > 0) begin want = exp_q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Scoreboard: every beat handed downstream must be the next expected one.
    always @(negedge clk) begin
        out_beat_t got;
        out_beat_t want;
        logic      ok;
        if (rst_in) begin
            for (int j = 0; j < 3; j++) begin
                if (bus.m_valid_o[j] && bus.m_ready_i[j]) begin
                    got.data = bus.m_data_o[j];
                    got.last = bus.m_last_o[j];
                    got.id   = bus.m_id_o[j];
                    pop_exp(j, want, ok);
                    chk($sformatf("expected_beat_p%0d", j), {31'd0, ok}, 32'd1);
                    if (ok) begin
                        chk($sformatf("beat_p%0d", j), 32'(got), 32'(want));
                        $display("beat port%0d data=0x%02h last=%0d id=%0d", j, got.data, got.last, got.id);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_data_i  = '0;
        bus.s_dest_i  = '0;
        bus.s_last_i  = '0;
        bus.s_valid_i = '0;
        bus.grant_i   = '0;
        bus.m_ready_i = '1;
        acc           = '0;
        rst_in        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
        chk("rst_m_last",  32'(bus.m_last_o),  32'd0);
        chk("rst_m_data",  32'(bus.m_data_o),  32'd0);
        chk("rst_m_id",    32'(bus.m_id_o),    32'd0);
        chk("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
        rst_in = 1'b1;

        // 1: two-beat packet slave0 -> port2, lock bubble then one beat per cycle
        bus.grant_i[2] = 1'b0;
        send(0, 2'd2, 8'hA1, 2);
        chk("t1_idle_s_ready", 32'(bus.s_ready_o), 32'd0);
        chk("t1_idle_m_valid", 32'(bus.m_valid_o), 32'd0);
        tick();
        chk("t1_lock_s_ready", 32'(bus.s_ready_o), 32'b01);
        chk("t1_lock_m_valid", 32'(bus.m_valid_o), 32'd0);
        tick();
        chk("t1_b0_m_valid", 32'(bus.m_valid_o), 32'b100);
        chk("t1_b0_data",    32'(bus.m_data_o[2]), 32'hA1);
        chk("t1_b0_id",      32'(bus.m_id_o[2]), 32'd0);
        chk("t1_b0_last",    32'(bus.m_last_o[2]), 32'd0);
        chk("t1_b0_s_ready", 32'(bus.s_ready_o), 32'b01);
        tick();
        chk("t1_b1_data",    32'(bus.m_data_o[2]), 32'hA2);
        chk("t1_b1_last",    32'(bus.m_last_o[2]), 32'd1);
        chk("t1_end_s_ready", 32'(bus.s_ready_o), 32'd0);
        tick();
        chk("t1_drained", 32'(bus.m_valid_o), 32'd0);

        // 2: downstream stall holds the first beat and blocks the slave
        send(0, 2'd2, 8'hA1, 2);
        tick();
        tick();
        bus.m_ready_i[2] = 1'b0;
        #1;
        chk("t2_stall_s_ready", 32'(bus.s_ready_o), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t2_hold_valid",   32'(bus.m_valid_o[2]), 32'd1);
            chk("t2_hold_data",    32'(bus.m_data_o[2]), 32'hA1);
            chk("t2_hold_s_ready", 32'(bus.s_ready_o), 32'd0);
        end
        bus.m_ready_i[2] = 1'b1;
        tick();
        chk("t2_resume_data", 32'(bus.m_data_o[2]), 32'hA2);
        chk("t2_resume_last", 32'(bus.m_last_o[2]), 32'd1);
        wait_drain("t2_drain");

        // 3: both slaves target port1; owner frozen across a grant change
        bus.grant_i[1] = 1'b1;
        send(1, 2'd1, 8'hB1, 3);
        send(0, 2'd1, 8'hC1, 2);
        chk("t3_idle_s_ready", 32'(bus.s_ready_o), 32'd0);
        tick();
        chk("t3_lock1_s_ready", 32'(bus.s_ready_o), 32'b10);
        tick();
        bus.grant_i[1] = 1'b0;
        tick();
        chk("t3_frozen_s_ready", 32'(bus.s_ready_o), 32'b10);
        tick();
        chk("t3_last_id",      32'(bus.m_id_o[1]), 32'd1);
        chk("t3_last_last",    32'(bus.m_last_o[1]), 32'd1);
        chk("t3_idle2_s_ready", 32'(bus.s_ready_o), 32'd0);
        tick();
        chk("t3_lock0_s_ready", 32'(bus.s_ready_o), 32'b01);
        wait_drain("t3_drain");

        // 4: disjoint pairs stream in parallel
        bus.grant_i[0] = 1'b0;
        bus.grant_i[2] = 1'b1;
        send(0, 2'd0, 8'h10, 4);
        send(1, 2'd2, 8'h20, 4);
        chk("t4_idle_s_ready", 32'(bus.s_ready_o), 32'd0);
        tick();
        chk("t4_lock_s_ready", 32'(bus.s_ready_o), 32'b11);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_m_valid", 32'(bus.m_valid_o), 32'b101);
            chk("t4_data_p0", 32'(bus.m_data_o[0]), 32'(8'h10 + 8'(k)));
            chk("t4_data_p2", 32'(bus.m_data_o[2]), 32'(8'h20 + 8'(k)));
            chk("t4_s_ready", 32'(bus.s_ready_o), (k < 3) ? 32'b11 : 32'b00);
        end
        wait_drain("t4_drain");

        // 5: reset mid-packet drops the buffered beat, then a fresh packet locks
        bus.grant_i[1] = 1'b0;
        send(0, 2'd1, 8'hD0, 4);
        tick();
        tick();
        chk("t5_buffered", 32'(bus.m_data_o[1]), 32'hD0);
        bus.m_ready_i[1] = 1'b0;
        rst_in = 1'b0;
        src_q0.delete();
        exp_q1.delete();
        drive_src();
        tick();
        rst_in = 1'b1;
        bus.m_ready_i = '1;
        #1;
        chk("t5_rst_m_valid", 32'(bus.m_valid_o), 32'd0);
        chk("t5_rst_s_ready", 32'(bus.s_ready_o), 32'd0);
        chk("t5_rst_data",    32'(bus.m_data_o[1]), 32'd0);
        send(0, 2'd1, 8'hE0, 2);
        chk("t5_idle_s_ready", 32'(bus.s_ready_o), 32'd0);
        tick();
        chk("t5_lock_s_ready", 32'(bus.s_ready_o), 32'b01);
        tick();
        chk("t5_b0_valid", 32'(bus.m_valid_o[1]), 32'd1);
        chk("t5_b0_data",  32'(bus.m_data_o[1]), 32'hE0);
        wait_drain("t5_drain");

        // 6: grant on the wrong slave keeps the port idle; single-beat packet
        bus.grant_i[0] = 1'b1;
        send(0, 2'd0, 8'hF0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_wait_s_ready", 32'(bus.s_ready_o[0]), 32'd0);
            chk("t6_wait_m_valid", 32'(bus.m_valid_o[0]), 32'd0);
        end
        bus.grant_i[0] = 1'b0;
        #1;
        tick();
        chk("t6_lock_s_ready", 32'(bus.s_ready_o), 32'b01);
        tick();
        chk("t6_valid", 32'(bus.m_valid_o[0]), 32'd1);
        chk("t6_data",  32'(bus.m_data_o[0]), 32'hF0);
        chk("t6_last",  32'(bus.m_last_o[0]), 32'd1);
        chk("t6_idle_s_ready", 32'(bus.s_ready_o), 32'd0);
        wait_drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
